// File: rtl/instr_encoder.sv
// Two-stage RISC-V instruction encoder: S1 registers decoded fields and a range/alignment
// error flag, S2 packs them into a 32-bit instruction word held until the consumer takes it.
module instr_encoder #(
    parameter int INSTRUCTION_LENGTH = 32,
    parameter int TYPE_WIDTH         = 3,
    parameter int REGISTER_WIDTH     = 5,
    parameter int IMMEDIATE_WIDTH    = 32,
    parameter int COUNT_WIDTH        = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [TYPE_WIDTH-1:0]         in_type,
    input  logic [6:0]                    in_opcode,
    input  logic [2:0]                    in_funct3,
    input  logic [6:0]                    in_funct7,
    input  logic [REGISTER_WIDTH-1:0]     in_rd,
    input  logic [REGISTER_WIDTH-1:0]     in_rs1,
    input  logic [REGISTER_WIDTH-1:0]     in_rs2,
    input  logic [IMMEDIATE_WIDTH-1:0]    in_imm,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [INSTRUCTION_LENGTH-1:0] out_instr,
    output logic                          out_err,
    output logic [COUNT_WIDTH-1:0]        enc_count,
    output logic [COUNT_WIDTH-1:0]        err_count
);

    localparam logic [TYPE_WIDTH-1:0] R_TYPE  = TYPE_WIDTH'(0);
    localparam logic [TYPE_WIDTH-1:0] I_TYPE  = TYPE_WIDTH'(1);
    localparam logic [TYPE_WIDTH-1:0] S_TYPE  = TYPE_WIDTH'(2);
    localparam logic [TYPE_WIDTH-1:0] SB_TYPE = TYPE_WIDTH'(3);
    localparam logic [TYPE_WIDTH-1:0] U_TYPE  = TYPE_WIDTH'(4);
    localparam logic [TYPE_WIDTH-1:0] UJ_TYPE = TYPE_WIDTH'(5);

    localparam logic signed [IMMEDIATE_WIDTH-1:0] IMM12_MIN = IMMEDIATE_WIDTH'(-2048);
    localparam logic signed [IMMEDIATE_WIDTH-1:0] IMM12_MAX = IMMEDIATE_WIDTH'(2047);
    localparam logic signed [IMMEDIATE_WIDTH-1:0] IMM13_MIN = IMMEDIATE_WIDTH'(-4096);
    localparam logic signed [IMMEDIATE_WIDTH-1:0] IMM13_MAX = IMMEDIATE_WIDTH'(4094);
    localparam logic signed [IMMEDIATE_WIDTH-1:0] IMM21_MIN = IMMEDIATE_WIDTH'(-1048576);
    localparam logic signed [IMMEDIATE_WIDTH-1:0] IMM21_MAX = IMMEDIATE_WIDTH'(1048574);

    // Handshake: a transfer happens on a rising edge where valid && ready; a producer
    // holds valid and its payload stable until that edge, and ready may depend on valid.
    logic                          r_s1_valid;
    logic [TYPE_WIDTH-1:0]         r_s1_type;
    logic [6:0]                    r_s1_opcode;
    logic [2:0]                    r_s1_funct3;
    logic [6:0]                    r_s1_funct7;
    logic [REGISTER_WIDTH-1:0]     r_s1_rd;
    logic [REGISTER_WIDTH-1:0]     r_s1_rs1;
    logic [REGISTER_WIDTH-1:0]     r_s1_rs2;
    logic [IMMEDIATE_WIDTH-1:0]    r_s1_imm;
    logic                          r_s1_err;

    logic                          r_out_valid;
    logic [INSTRUCTION_LENGTH-1:0] r_out_instr;
    logic                          r_out_err;
    logic [COUNT_WIDTH-1:0]        r_enc_count;
    logic [COUNT_WIDTH-1:0]        r_err_count;

    logic                          w_s2_ready;
    logic                          w_in_fire;
    logic                          w_out_fire;
    logic                          w_err_in;
    logic signed [IMMEDIATE_WIDTH-1:0] w_imm;
    logic [INSTRUCTION_LENGTH-1:0] w_packed;

    assign w_s2_ready = !r_out_valid || out_ready;
    assign in_ready   = !r_s1_valid || w_s2_ready;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_out_valid && out_ready;
    assign w_imm      = $signed(in_imm);

    // Branch and jump offsets must be even; U immediates carry only the upper 20 bits.
    always_comb begin
        w_err_in = 1'b0;
        case (in_type)
            R_TYPE:         w_err_in = 1'b0;
            I_TYPE, S_TYPE: w_err_in = (w_imm < IMM12_MIN) || (w_imm > IMM12_MAX);
            SB_TYPE:        w_err_in = (w_imm < IMM13_MIN) || (w_imm > IMM13_MAX) || in_imm[0];
            U_TYPE:         w_err_in = (in_imm[11:0] != 12'd0);
            UJ_TYPE:        w_err_in = (w_imm < IMM21_MIN) || (w_imm > IMM21_MAX) || in_imm[0];
            default:        w_err_in = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_type   <= '0;
            r_s1_opcode <= '0;
            r_s1_funct3 <= '0;
            r_s1_funct7 <= '0;
            r_s1_rd     <= '0;
            r_s1_rs1    <= '0;
            r_s1_rs2    <= '0;
            r_s1_imm    <= '0;
            r_s1_err    <= 1'b0;
        end else if (w_in_fire) begin
            r_s1_valid  <= 1'b1;
            r_s1_type   <= in_type;
            r_s1_opcode <= in_opcode;
            r_s1_funct3 <= in_funct3;
            r_s1_funct7 <= in_funct7;
            r_s1_rd     <= in_rd;
            r_s1_rs1    <= in_rs1;
            r_s1_rs2    <= in_rs2;
            r_s1_imm    <= in_imm;
            r_s1_err    <= w_err_in;
        end else if (w_s2_ready) begin
            r_s1_valid  <= 1'b0;
        end
    end

    always_comb begin
        w_packed = '0;
        if (!r_s1_err) begin
            case (r_s1_type)
                R_TYPE:  w_packed = {r_s1_funct7, r_s1_rs2, r_s1_rs1, r_s1_funct3, r_s1_rd, r_s1_opcode};
                I_TYPE:  w_packed = {r_s1_imm[11:0], r_s1_rs1, r_s1_funct3, r_s1_rd, r_s1_opcode};
                S_TYPE:  w_packed = {r_s1_imm[11:5], r_s1_rs2, r_s1_rs1, r_s1_funct3,
                                     r_s1_imm[4:0], r_s1_opcode};
                SB_TYPE: w_packed = {r_s1_imm[12], r_s1_imm[10:5], r_s1_rs2, r_s1_rs1, r_s1_funct3,
                                     r_s1_imm[4:1], r_s1_imm[11], r_s1_opcode};
                U_TYPE:  w_packed = {r_s1_imm[31:12], r_s1_rd, r_s1_opcode};
                UJ_TYPE: w_packed = {r_s1_imm[20], r_s1_imm[10:1], r_s1_imm[11], r_s1_imm[19:12],
                                     r_s1_rd, r_s1_opcode};
                default: w_packed = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_out_instr <= '0;
            r_out_err   <= 1'b0;
        end else if (w_s2_ready) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_instr <= w_packed;
                r_out_err   <= r_s1_err;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_enc_count <= '0;
            r_err_count <= '0;
        end else if (w_out_fire) begin
            r_enc_count <= r_enc_count + COUNT_WIDTH'(1);
            if (r_out_err) begin
                r_err_count <= r_err_count + COUNT_WIDTH'(1);
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_instr = r_out_instr;
    assign out_err   = r_out_err;
    assign enc_count = r_enc_count;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: scoreboard queue of {err, word} pushed on input acceptance,
// popped on each output handshake; directed vectors, boundary table, backpressure, reset.
module tb_instr_encoder;
  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_type;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] enc_count;
  logic [15:0] err_count;

  logic [32:0] exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [15:0] exp_enc = 0;
  logic [15:0] exp_errc = 0;

  instr_encoder dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_type(in_type), .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_err(out_err),
    .enc_count(enc_count), .err_count(err_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [2:0] t, input logic [6:0] op,
      input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    logic [31:0] w;
    w = '0;
    w[6:0] = op;
    case (t)
      3'd0: begin w[11:7] = rd; w[14:12] = f3; w[19:15] = rs1; w[24:20] = rs2; w[31:25] = f7; end
      3'd1: begin w[11:7] = rd; w[14:12] = f3; w[19:15] = rs1; w[31:20] = imm[11:0]; end
      3'd2: begin w[11:7] = imm[4:0]; w[14:12] = f3; w[19:15] = rs1; w[24:20] = rs2;
                  w[31:25] = imm[11:5]; end
      3'd3: begin w[7] = imm[11]; w[11:8] = imm[4:1]; w[14:12] = f3; w[19:15] = rs1;
                  w[24:20] = rs2; w[30:25] = imm[10:5]; w[31] = imm[12]; end
      3'd4: begin w[11:7] = rd; w[31:12] = imm[31:12]; end
      3'd5: begin w[11:7] = rd; w[19:12] = imm[19:12]; w[20] = imm[11]; w[30:21] = imm[10:1];
                  w[31] = imm[20]; end
      default: w = '0;
    endcase
    return w;
  endfunction

  // driver: called at a negedge, returns at the negedge after acceptance
  task automatic send(input logic [2:0] t, input logic [6:0] op, input logic [2:0] f3,
      input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [31:0] imm, input logic [31:0] exp_word, input logic exp_e);
    int n;
    in_type = t; in_opcode = op; in_funct3 = f3; in_funct7 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_valid = 1'b1;
    n = 0;
    #1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 100) begin
      check("in_ready_timeout", 64'd0, 64'd1);
    end else begin
      exp_q.push_back({exp_e, exp_e ? 32'd0 : exp_word});
      exp_enc = exp_enc + 16'd1;
      if (exp_e) exp_errc = exp_errc + 16'd1;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_m(input logic [2:0] t, input logic [31:0] imm, input logic exp_e);
    send(t, 7'h13, 3'd5, 7'h20, 5'd9, 5'd17, 5'd30, imm,
         ref_word(t, 7'h13, 3'd5, 7'h20, 5'd9, 5'd17, 5'd30, imm), exp_e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    #3;
    check("enc_count", 64'(enc_count), 64'(exp_enc));
    check("err_count", 64'(err_count), 64'(exp_errc));
  endtask

  // scoreboard monitor
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (reset_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", {31'd0, out_err, out_instr}, 64'hdead);
        end else begin
          e = exp_q.pop_front();
          check("out_word", {31'd0, out_err, out_instr}, {31'd0, e});
        end
      end
    end
  end

  logic [2:0]  bt_t[20];
  logic [31:0] bt_i[20];
  logic        bt_e[20];

  initial begin
    in_valid = 0; in_type = 0; in_opcode = 0; in_funct3 = 0; in_funct7 = 0;
    in_rd = 0; in_rs1 = 0; in_rs2 = 0; in_imm = 0; out_ready = 1;
    reset_n = 0;
    bt_t = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3,
             3'd3, 3'd5, 3'd5, 3'd5, 3'd5, 3'd4, 3'd4, 3'd6, 3'd7, 3'd0};
    bt_i = '{32'd2047, -32'sd2048, 32'd2048, -32'sd2049, -32'sd2048, 32'd2048,
             32'd4094, -32'sd4096, 32'd4096, -32'sd4098, 32'd6,
             32'd1048574, -32'sd1048576, 32'd1048576, 32'd3,
             32'hFFFFF000, 32'h00000800, 32'd0, 32'd0, 32'hFFFFFFFF};
    bt_e = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1,
             1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    #22;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_instr", 64'(out_instr), 64'd0);
    check("rst_out_err", 64'(out_err), 64'd0);
    check("rst_enc_count", 64'(enc_count), 64'd0);
    check("rst_err_count", 64'(err_count), 64'd0);
    @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // addi x1, x2, -1 with two-cycle latency
    @(negedge clk);
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFF, 32'hFFF10093, 1'b0);
    #1;
    check("lat_s1_only", 64'(out_valid), 64'd0);
    @(negedge clk);
    #1;
    check("lat_out_valid", 64'(out_valid), 64'd1);
    @(negedge clk);
    drain();

    // back-to-back add x3, x1, x2
    @(negedge clk);
    begin
      int c0;
      c0 = cyc;
      for (int i = 0; i < 4; i++)
        send(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3, 1'b0);
      check("b2b_cycles", 64'(cyc - c0), 64'd4);
    end
    drain();

    // beq and lui directed vectors
    @(negedge clk);
    send(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd8, 32'h00000463, 1'b0);
    send(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd7, 32'd0, 1'b1);
    send(3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 32'h123452B7, 1'b0);
    send(3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345001, 32'd0, 1'b1);
    drain();

    // range / alignment boundaries and undefined types
    @(negedge clk);
    for (int i = 0; i < 20; i++) send_m(bt_t[i], bt_i[i], bt_e[i]);
    for (int i = 0; i < 8; i++)
      send_m(3'd1, 32'($signed($urandom_range(0, 4095)) - 2048), 1'b0);
    drain();

    // backpressure: three inputs with consumer stalled for five cycles
    @(negedge clk);
    out_ready = 0;
    fork
      begin
        send(3'd1, 7'h13, 3'd0, 7'd0, 5'd10, 5'd0, 5'd0, 32'd10, 32'h00A00513, 1'b0);
        send(3'd1, 7'h13, 3'd0, 7'd0, 5'd11, 5'd0, 5'd0, 32'd11, 32'h00B00593, 1'b0);
        send(3'd1, 7'h13, 3'd0, 7'd0, 5'd12, 5'd0, 5'd0, 32'd12, 32'h00C00613, 1'b0);
      end
      begin
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
          #3;
          check("bp_in_ready", 64'(in_ready), 64'd0);
          check("bp_held", {31'd0, out_valid, out_instr}, {31'd0, 1'b1, 32'h00A00513});
          @(negedge clk);
        end
        out_ready = 1;
      end
    join
    drain();

    // reset mid-stream
    @(negedge clk);
    out_ready = 0;
    send(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3, 1'b0);
    send(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3, 1'b0);
    #3;
    reset_n = 0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_enc_count", 64'(enc_count), 64'd0);
    check("mid_rst_err_count", 64'(err_count), 64'd0);
    exp_q.delete();
    exp_enc = 0;
    exp_errc = 0;
    @(negedge clk);
    reset_n = 1;
    out_ready = 1;
    @(negedge clk);
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFF, 32'hFFF10093, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
